// File: rtl/ps2_host_tx_if.sv
// Command-side handshake plus raw PS/2 pin levels and pin-drive enables of the host transmitter.
// The slave modport is the transmitter; the master modport is whoever issues bytes and owns the pins.
interface ps2_host_tx_if;
    logic [7:0] data_in;
    logic       send;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output data_in, send, ps2_clk_in, ps2_data_in,
        input  ps2_clk_oe, ps2_data_oe, busy, done, err
    );

    modport slave (
        input  data_in, send, ps2_clk_in, ps2_data_in,
        output ps2_clk_oe, ps2_data_oe, busy, done, err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte sender: inhibit, start, 8 data LSB first, odd parity, stop, ack check.
// Busy from accepted send until done/err; send ignored while busy. PS2_TX_TIMEOUT_EN adds a watchdog.
module ps2_host_tx #(
    parameter int TICKS_PER_US = 50,
    parameter int INHIBIT_US   = 100,
    parameter int SETUP_US     = 2,
    parameter int TIMEOUT_US   = 15000
) (
    input  logic         qzt_clk,
    input  logic         rst_n,
    ps2_host_tx_if.slave bus
);
    localparam int DIV_W  = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int MAX_A  = (INHIBIT_US > TIMEOUT_US) ? INHIBIT_US : TIMEOUT_US;
    localparam int US_MAX = (MAX_A > SETUP_US) ? MAX_A : SETUP_US;
    localparam int US_W   = $clog2(US_MAX + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

    state_t           state, state_n;
    logic [2:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_s, data_s, fall, tick;
    logic [DIV_W-1:0] div_cnt;
    logic [US_W-1:0]  us_cnt, us_n;
    logic [8:0]       shreg, shreg_n;
    logic [3:0]       idx, idx_n;
    logic             data_oe_q, data_oe_n;
    logic             done_q, done_n, err_q, err_n;

    // Lines idle high, so the synchronisers reset to 1 to avoid a spurious fall after reset.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], bus.ps2_clk_in};
            data_sync <= {data_sync[0], bus.ps2_data_in};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign tick   = (div_cnt == DIV_W'(TICKS_PER_US - 1));

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

`ifdef PS2_TX_TIMEOUT_EN
    logic [US_W-1:0] wd_cnt;
    logic            wd_hit;

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n)              wd_cnt <= '0;
        else if (state == IDLE)  wd_cnt <= '0;
        else if (tick)           wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_hit = (state != IDLE) && tick && (wd_cnt == US_W'(TIMEOUT_US - 1));
`endif

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            us_cnt    <= '0;
            shreg     <= '0;
            idx       <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            us_cnt    <= us_n;
            shreg     <= shreg_n;
            idx       <= idx_n;
            data_oe_q <= data_oe_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        us_n      = us_cnt;
        shreg_n   = shreg;
        idx_n     = idx;
        data_oe_n = data_oe_q;
        done_n    = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                data_oe_n = 1'b0;
                // A send coinciding with the done/err pulse is dropped.
                if (bus.send && !done_q && !err_q) begin
                    shreg_n = {~^bus.data_in, bus.data_in};
                    us_n    = '0;
                    idx_n   = '0;
                    state_n = INHIBIT;
                end
            end
            INHIBIT: if (tick) begin
                if (us_cnt == US_W'(INHIBIT_US - 1)) begin
                    us_n      = '0;
                    data_oe_n = 1'b1;
                    state_n   = REQ;
                end else begin
                    us_n = us_cnt + 1'b1;
                end
            end
            REQ: if (tick) begin
                if (us_cnt == US_W'(SETUP_US - 1)) begin
                    us_n    = '0;
                    idx_n   = '0;
                    state_n = SHIFT;
                end else begin
                    us_n = us_cnt + 1'b1;
                end
            end
            SHIFT: if (fall) begin
                data_oe_n = (idx <= 4'd8) ? ~shreg[idx] : 1'b0;
                idx_n     = idx + 4'd1;
                if (idx == 4'd9) state_n = ACK;
            end
            ACK: if (fall) begin
                if (!data_s) begin
                    state_n = WAIT_IDLE;
                end else begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_IDLE: if (clk_s && data_s) begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (wd_hit) begin
            state_n   = IDLE;
            data_oe_n = 1'b0;
            done_n    = 1'b0;
            err_n     = 1'b1;
        end
`endif
    end

    assign bus.ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pin model plus a PS/2 device that clocks frames in and optionally acks.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int T    = 10;
    localparam int INH  = 100;
    localparam int SU   = 2;
    localparam int TO   = 1000;
    localparam int HALF = 40;

    logic qzt_clk = 1'b0;
    logic rst_n;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic clk_line, data_line;
    int   checks = 0, failures = 0;
    int   done_cnt = 0, err_cnt = 0, fall_no = 0;

    ps2_host_tx_if bus ();

    assign clk_line        = ~(bus.ps2_clk_oe  | dev_clk_low);
    assign data_line       = ~(bus.ps2_data_oe | dev_data_low);
    assign bus.ps2_clk_in  = clk_line;
    assign bus.ps2_data_in = data_line;

    ps2_host_tx #(
        .TICKS_PER_US(T),
        .INHIBIT_US  (INH),
        .SETUP_US    (SU),
        .TIMEOUT_US  (TO)
    ) dut (
        .qzt_clk(qzt_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 qzt_clk = ~qzt_clk;

    always @(negedge qzt_clk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.err === 1'b1)  err_cnt++;
    end

    // Wire order as the device sees it: data[0..7], odd parity, stop.
    function automatic logic [9:0] expected_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge qzt_clk);
    endtask

    task automatic start_frame(input logic [7:0] b, output int inh);
        @(negedge qzt_clk);
        bus.data_in = b;
        bus.send    = 1'b1;
        @(negedge qzt_clk);
        bus.send = 1'b0;
        inh = 0;
        while (bus.ps2_clk_oe && !bus.ps2_data_oe && inh < 4 * INH * T) begin
            inh++;
            @(negedge qzt_clk);
        end
    endtask

    task automatic device_frame(input bit ack, output logic [9:0] seen, output bit started);
        int n;
        seen = '0;
        started = 1'b0;
        n = 0;
        while (!(clk_line && !data_line) && n < 4 * INH * T) begin
            n++;
            @(negedge qzt_clk);
        end
        if (clk_line && !data_line) begin
            started = 1'b1;
            wait_cyc(HALF);
            for (int k = 0; k < 10; k++) begin
                dev_clk_low = 1'b1;
                fall_no = k + 1;
                wait_cyc(HALF);
                dev_clk_low = 1'b0;
                seen[k] = data_line;
                wait_cyc(HALF);
            end
            dev_data_low = ack;
            wait_cyc(HALF / 2);
            dev_clk_low = 1'b1;
            fall_no = 11;
            wait_cyc(HALF);
            dev_clk_low = 1'b0;
            wait_cyc(HALF / 2);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_end(input int d0, input int e0);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 500) begin
            n++;
            @(negedge qzt_clk);
        end
        wait_cyc(2);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, output logic [9:0] seen,
                             output bit started, output int inh, output int dd, output int de);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        fall_no = 0;
        start_frame(b, inh);
        device_frame(ack, seen, started);
        wait_end(d0, e0);
        dd = done_cnt - d0;
        de = err_cnt - e0;
    endtask

    task automatic test_reset;
        bus.send    = 1'b0;
        bus.data_in = 8'h00;
        rst_n       = 1'b0;
        wait_cyc(4);
        checks++;
        if ({bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy, bus.done, bus.err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy, bus.done, bus.err});
        end
        rst_n = 1'b1;
        wait_cyc(8);
        checks++;
        if ({bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy, bus.done, bus.err} !== 5'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=00000",
                     {bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy, bus.done, bus.err});
        end
    endtask

    task automatic test_f4;
        logic [9:0] seen;
        bit started;
        int inh, dd, de;
        run_frame(8'hF4, 1'b1, seen, started, inh, dd, de);
        checks++;
        if (started !== 1'b1) begin failures++; $display("FAIL f4_start got=%b exp=1", started); end
        checks++;
        if (seen !== 10'h2F4) begin failures++; $display("FAIL f4_bits got=%h exp=2f4", seen); end
        checks++;
        if (seen !== expected_frame(8'hF4)) begin
            failures++; $display("FAIL f4_model got=%h exp=%h", seen, expected_frame(8'hF4));
        end
        checks++;
        if (dd !== 1 || de !== 0) begin failures++; $display("FAIL f4_done done=%0d err=%0d exp=1/0", dd, de); end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL f4_busy_clear got=%b exp=0", bus.busy); end
    endtask

    task automatic test_ff;
        logic [9:0] seen;
        bit started;
        int inh, dd, de;
        run_frame(8'hFF, 1'b1, seen, started, inh, dd, de);
        checks++;
        if (seen[8] !== 1'b1) begin failures++; $display("FAIL ff_parity got=%b exp=1", seen[8]); end
        checks++;
        if (seen !== expected_frame(8'hFF)) begin
            failures++; $display("FAIL ff_model got=%h exp=%h", seen, expected_frame(8'hFF));
        end
        checks++;
        if (inh < INH * T - T || inh > INH * T + T) begin
            failures++; $display("FAIL inhibit_len got=%0d exp=%0d+-%0d", inh, INH * T, T);
        end
        checks++;
        if (dd !== 1 || de !== 0) begin failures++; $display("FAIL ff_done done=%0d err=%0d exp=1/0", dd, de); end
    endtask

    task automatic test_random;
        logic [9:0] seen;
        logic [7:0] b;
        bit started;
        int inh, dd, de;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            run_frame(b, 1'b1, seen, started, inh, dd, de);
            checks++;
            if (seen !== expected_frame(b)) begin
                failures++; $display("FAIL rand_bits[%0d] byte=%h got=%h exp=%h", i, b, seen, expected_frame(b));
            end
            checks++;
            if (dd !== 1 || de !== 0) begin
                failures++; $display("FAIL rand_done[%0d] done=%0d err=%0d exp=1/0", i, dd, de);
            end
        end
    endtask

    task automatic test_no_ack;
        logic [9:0] seen;
        logic [7:0] b;
        bit started;
        int inh, dd, de;
        b = 8'($urandom_range(0, 255));
        run_frame(b, 1'b0, seen, started, inh, dd, de);
        checks++;
        if (de !== 1 || dd !== 0) begin failures++; $display("FAIL noack_err err=%0d done=%0d exp=1/0", de, dd); end
        checks++;
        if ({bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy} !== 3'b000) begin
            failures++; $display("FAIL noack_release got=%b exp=000", {bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy});
        end
        checks++;
        if (seen !== expected_frame(b)) begin
            failures++; $display("FAIL noack_bits got=%h exp=%h", seen, expected_frame(b));
        end
    endtask

    task automatic test_busy_ignore;
        logic [9:0] seen;
        logic [7:0] b;
        bit started;
        int inh, n, d0, e0;
        b = 8'($urandom_range(1, 255));
        d0 = done_cnt;
        e0 = err_cnt;
        fall_no = 0;
        start_frame(b, inh);
        fork
            device_frame(1'b1, seen, started);
            begin
                n = 0;
                while (fall_no < 3 && n < 4 * INH * T) begin n++; @(negedge qzt_clk); end
                bus.data_in = 8'h00;
                bus.send    = 1'b1;
                @(negedge qzt_clk);
                bus.send = 1'b0;
                checks++;
                if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_midframe got=%b exp=1", bus.busy); end
            end
        join
        wait_end(d0, e0);
        checks++;
        if (seen !== expected_frame(b)) begin
            failures++; $display("FAIL ignore_bits got=%h exp=%h", seen, expected_frame(b));
        end
        checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            failures++; $display("FAIL ignore_done done=%0d err=%0d exp=1/0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_send_on_done;
        logic [9:0] seen;
        logic [7:0] b1, b2;
        bit started;
        int inh, n, d0, e0;
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        fall_no = 0;
        start_frame(b1, inh);
        device_frame(1'b1, seen, started);
        n = 0;
        while (bus.done !== 1'b1 && n < 500) begin n++; @(negedge qzt_clk); end
        checks++;
        if (bus.done !== 1'b1) begin failures++; $display("FAIL done_pulse got=%b exp=1", bus.done); end
        bus.data_in = ~b2;
        bus.send    = 1'b1;
        @(negedge qzt_clk);
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL send_on_done_ignored busy=%b exp=0", bus.busy); end
        bus.data_in = b2;
        @(negedge qzt_clk);
        bus.send = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL send_next_cycle busy=%b exp=1", bus.busy); end
        d0 = done_cnt;
        e0 = err_cnt;
        fall_no = 0;
        device_frame(1'b1, seen, started);
        wait_end(d0, e0);
        checks++;
        if (seen !== expected_frame(b2)) begin
            failures++; $display("FAIL next_bits got=%h exp=%h", seen, expected_frame(b2));
        end
        checks++;
        if (done_cnt - d0 !== 1) begin failures++; $display("FAIL next_done got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_timeout;
        int  n, e0, el;
        time t0;
        e0 = err_cnt;
        @(negedge qzt_clk);
        bus.data_in = 8'($urandom_range(0, 255));
        bus.send    = 1'b1;
        @(negedge qzt_clk);
        bus.send = 1'b0;
        t0 = $time;
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        while (bus.err !== 1'b1 && n < TO * T + 5 * T) begin n++; @(negedge qzt_clk); end
        el = int'(($time - t0) / 10);
        checks++;
        if (bus.err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", bus.err); end
        checks++;
        if (el < TO * T - T || el > TO * T + T) begin
            failures++; $display("FAIL timeout_time got=%0d exp=%0d+-%0d", el, TO * T, T);
        end
        checks++;
        if ({bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy} !== 3'b000) begin
            failures++; $display("FAIL timeout_release got=%b exp=000", {bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy});
        end
        wait_cyc(4);
`else
        n = 0;
        wait_cyc(TO * T + 5 * T);
        el = int'(($time - t0) / 10);
        checks++;
        if (bus.busy !== 1'b1 || el < TO * T) begin
            failures++; $display("FAIL no_watchdog_busy got=%b after %0d cycles exp=1", bus.busy, el);
        end
        checks++;
        if (err_cnt !== e0 + n) begin failures++; $display("FAIL no_watchdog_err got=%0d exp=0", err_cnt - e0); end
        @(negedge qzt_clk);
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(4);
`endif
    endtask

    task automatic test_reset_mid;
        logic [9:0] seen;
        logic [7:0] b;
        bit started;
        int inh, n, d0, dd, de;
        b = 8'($urandom_range(0, 255)) & 8'hEF;
        d0 = done_cnt;
        fall_no = 0;
        start_frame(b, inh);
        fork
            device_frame(1'b1, seen, started);
            begin
                n = 0;
                while (fall_no < 5 && n < 4 * INH * T) begin n++; @(negedge qzt_clk); end
                wait_cyc(HALF / 2);
                checks++;
                if (bus.ps2_data_oe !== 1'b1) begin
                    failures++; $display("FAIL bit4_driven got=%b exp=1", bus.ps2_data_oe);
                end
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if ({bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy} !== 3'b000) begin
                    failures++; $display("FAIL async_reset got=%b exp=000", {bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy});
                end
            end
        join
        checks++;
        if (done_cnt !== d0) begin failures++; $display("FAIL aborted_done got=%0d exp=0", done_cnt - d0); end
        @(negedge qzt_clk);
        rst_n = 1'b1;
        wait_cyc(8);
        b = 8'($urandom_range(0, 255));
        run_frame(b, 1'b1, seen, started, inh, dd, de);
        checks++;
        if (seen !== expected_frame(b)) begin
            failures++; $display("FAIL post_reset_bits got=%h exp=%h", seen, expected_frame(b));
        end
        checks++;
        if (dd !== 1 || de !== 0) begin failures++; $display("FAIL post_reset_done done=%0d err=%0d exp=1/0", dd, de); end
    endtask

    initial begin
        test_reset();
        test_f4();
        test_ff();
        test_random();
        test_no_ack();
        test_busy_ignore();
        test_send_on_done();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
